// File: rtl/icache_pkg.sv
// icache_pkg: shared widths, geometry and FSM state type for the read-only instruction cache
package icache_pkg;
    localparam int DEF_LINES  = 8;
    localparam int LINE_W     = 128;
    localparam int WORD_W     = 32;
    localparam int ADDR_W     = 30;
    localparam int MEM_ADDR_W = 28;
    localparam int INDEX_W    = $clog2(DEF_LINES);
    localparam int TAG_W      = ADDR_W - 2 - INDEX_W;
    typedef enum logic {S_IDLE, S_FILL} state_t;
endpackage

// File: rtl/icache_line_store.sv
// icache_line_store: flop-based valid/tag/data arrays, combinational read, one synchronous write
module icache_line_store
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int IW    = INDEX_W,
    parameter int TW    = TAG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IW-1:0]     rd_idx,
    output logic              rd_valid,
    output logic [TW-1:0]     rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              we,
    input  logic [IW-1:0]     wr_idx,
    input  logic [TW-1:0]     wr_tag,
    input  logic [LINE_W-1:0] wr_line
);
    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tags [LINES];
    logic [LINE_W-1:0] data [LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_line  = data[rd_idx];

    // valid bits clear on reset; a fill marks its line valid
    always_ff @(posedge clk) begin
        if (rst) valid <= '0;
        else if (we) valid[wr_idx] <= 1'b1;
    end

    // tag and data install alongside the valid bit, suppressed while in reset
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            tags[wr_idx] <= wr_tag;
            data[wr_idx] <= wr_line;
        end
    end
endmodule

// File: rtl/icache_ro.sv
// icache_ro: direct-mapped read-only I-cache; optional ICACHE_PERF_CNT_EN enables saturating hit/miss counters
module icache_ro
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ICACHE_ren,
    input  logic                  ICACHE_wen,
    input  logic [ADDR_W-1:0]     ICACHE_addr,
    input  logic [WORD_W-1:0]     ICACHE_wdata,
    output logic [WORD_W-1:0]     ICACHE_rdata,
    output logic                  ICACHE_stall,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]     mem_wdata,
    input  logic [LINE_W-1:0]     mem_rdata,
    input  logic                  mem_ready,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);
    localparam int IW = $clog2(LINES);
    localparam int TW = ADDR_W - 2 - IW;

    state_t            state;
    logic              rd_valid;
    logic [TW-1:0]     rd_tag;
    logic [LINE_W-1:0] rd_line;
    logic              hit;
    logic              fill_done;
    logic              unused_wr;

    assign unused_wr = ^{ICACHE_wen, ICACHE_wdata};
    assign mem_write = 1'b0;
    assign mem_wdata = '0;

    assign hit          = rd_valid && rd_tag == ICACHE_addr[ADDR_W-1:2+IW];
    assign fill_done    = state == S_FILL && mem_ready;
    assign ICACHE_rdata = rd_line[{ICACHE_addr[1:0], 5'd0} +: WORD_W];
    assign ICACHE_stall = state == S_FILL || (ICACHE_ren && !hit);

    icache_line_store #(.LINES(LINES), .IW(IW), .TW(TW)) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (ICACHE_addr[2+IW-1:2]),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (fill_done),
        .wr_idx   (mem_addr[IW-1:0]),
        .wr_tag   (mem_addr[MEM_ADDR_W-1:IW]),
        .wr_line  (mem_rdata)
    );

    // miss FSM: latch the line address on a miss, hold the request until mem_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mem_read <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                S_IDLE: if (ICACHE_ren && !hit) begin
                    state    <= S_FILL;
                    mem_read <= 1'b1;
                    mem_addr <= ICACHE_addr[ADDR_W-1:2];
                end
                S_FILL: if (mem_ready) begin
                    state    <= S_IDLE;
                    mem_read <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // saturating counters sampled only on IDLE lookups
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == S_IDLE && ICACHE_ren) begin
            if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_icache_ro.sv
// tb_icache_ro: scoreboard bench for icache_ro covering fills, hits, eviction, fast fill and reset mid-fill
module tb_icache_ro;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ren = 1'b0;
    logic         wen = 1'b0;
    logic [29:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    int           vectors = 0;
    int           miscompares = 0;
    logic [31:0]  exp_q[$];

    always #5 clk = ~clk;

    icache_ro dut (
        .clk          (clk),
        .rst          (rst),
        .ICACHE_ren   (ren),
        .ICACHE_wen   (wen),
        .ICACHE_addr  (addr),
        .ICACHE_wdata (wdata),
        .ICACHE_rdata (rdata),
        .ICACHE_stall (stall),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one read request; fill answered with mem_ready on FILL cycle rdy; result popped from scoreboard
    task automatic access(input logic [29:0] a, input int rdy, output int stalls, output logic [27:0] fill_addr);
        int fills;
        bit done;
        stalls = 0;
        fills = 0;
        done = 0;
        fill_addr = '0;
        @(posedge clk);
        #1;
        ren = 1'b1;
        addr = a;
        mem_ready = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
            end else begin
                stalls++;
                if (mem_read) begin
                    fills++;
                    fill_addr = mem_addr;
                    mem_ready = (fills == rdy);
                end
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
            end
        end
        if (!done) check("stall_timeout", 1'b1, 1'b0);
        else check("rdata", rdata, exp_q.pop_front());
    endtask

    int          st;
    logic [27:0] fa;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_stall", stall, 1'b0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_addr", mem_addr, 28'h0);
        check("rst_hit_cnt", hit_cnt, 32'h0);
        check("rst_miss_cnt", miss_cnt, 32'h0);
        check("mem_write", mem_write, 1'b0);
        check("mem_wdata", mem_wdata, 128'h0);

        mem_rdata = {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA};
        exp_q.push_back(32'hAAAA);
        access(30'h4, 3, st, fa);
        check("cold_stalls", st, 4);
        check("cold_mem_addr", fa, 28'h1);

        for (int k = 1; k < 4; k++) begin
            logic [31:0] w;
            w = mem_rdata[32*k +: 32];
            exp_q.push_back(w);
            access(30'h4 + 30'(k), 0, st, fa);
            check("hit_stalls", st, 0);
            check("hit_mem_read", mem_read, 1'b0);
        end
        @(posedge clk);
        #1;
        ren = 1'b0;
        @(negedge clk);
`ifdef ICACHE_PERF_CNT_EN
        check("hit_cnt", hit_cnt, 32'd4);
        check("miss_cnt", miss_cnt, 32'd1);
`else
        check("hit_cnt", hit_cnt, 32'd0);
        check("miss_cnt", miss_cnt, 32'd0);
`endif

        mem_rdata = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
        exp_q.push_back(32'h1111);
        access(30'h24, 2, st, fa);
        check("evict_stalls", st, 3);
        check("evict_mem_addr", fa, 28'h9);

        mem_rdata = {32'h8888, 32'h7777, 32'h6666, 32'h5555};
        exp_q.push_back(32'h5555);
        access(30'h4, 1, st, fa);
        check("fast_stalls", st, 2);
        check("fast_mem_addr", fa, 28'h1);
        exp_q.push_back(32'h7777);
        access(30'h6, 0, st, fa);
        check("fast_installed", st, 0);

        @(posedge clk);
        #1;
        addr = 30'h40;
        for (int i = 0; i < 10 && !mem_read; i++) @(negedge clk);
        check("mid_fill_mem_read", mem_read, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ren = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check("post_rst_mem_read", mem_read, 1'b0);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("late_ready_mem_read", mem_read, 1'b0);

        exp_q.push_back(32'h5555);
        access(30'h4, 1, st, fa);
        check("post_rst_miss", st, 2);
        mem_rdata = {32'hD0D0, 32'hC0C0, 32'hB0B0, 32'hA0A0};
        exp_q.push_back(32'hA0A0);
        access(30'h40, 1, st, fa);
        check("post_rst_refill", st, 2);
        check("post_rst_mem_addr", fa, 28'h10);
        @(posedge clk);
        #1;
        ren = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
